lcd_ctrl: RTL and testbench

Hardware HD44780 write sequencer that sits directly downstream of the output-peripheral memory. It consumes the 32-bit LCD register word that the memory presents at 0x7030. Firmware writes RS and data and flips a "go" bit. The block then generates the LCD bus cycle with correct setup, enable-pulse, hold and execution timing. It exposes busy/done status for the input-peripheral path, so software no longer bit-bangs the LCD pins.

---
 rtl/lcd_pkg.sv | 32 +++
 rtl/lcd_timer.sv | 30 +++
 rtl/lcd_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lcd_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write sequencer.
//   lcd_state_e : sequencer phases of one LCD bus write
//   LCD_*_BIT   : field positions inside the memory-mapped LCD register word
//   lcd_req_t   : one write request (register select + data byte)
//   is_long_cmd : true for clear/home commands, which need the long execution wait
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_e;

  localparam int LCD_ON_BIT   = 31;
  localparam int LCD_GO_BIT   = 10;
  localparam int LCD_RS_BIT   = 9;
  localparam int LCD_DATA_MSB = 7;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_req_t;

  // Instruction writes 0x01 (clear) and 0x02/0x03 (return home) run far longer
  // than any other command or data write.
  function automatic logic is_long_cmd(input lcd_req_t req);
    return !req.rs && (req.data[7:2] == 6'd0) && (req.data[1:0] != 2'd0);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter used to time each sequencer phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load the counter with value (takes priority over counting)
//   value      : reload value, phase length minus one
//   zero       : counter has reached zero (it then holds at zero)
module lcd_timer #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer fed by the memory-mapped LCD register word.
// Firmware sets RS/data and toggles GO; this block drives setup, enable pulse,
// hold and execution wait, with a single pending slot for back-to-back writes.
//   i_clk, i_rst  : clock, asynchronous active-low reset
//   i_lcd_word    : [31]=ON, [10]=GO toggle, [9]=RS, [7:0]=data
//   o_lcd_data/rs : LCD bus data and register select, held between writes
//   o_lcd_rw      : tied low (write-only)
//   o_lcd_en      : enable strobe
//   o_lcd_on      : registered power/backlight bit
//   o_lcd_busy    : transaction running or request pending
//   o_lcd_done    : one-cycle pulse after each transaction's execution wait
//   o_lcd_drop    : one-cycle pulse when a request is lost (pending slot full)
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_AS_CYC   = 2,
  parameter int T_PW_CYC   = 12,
  parameter int T_H_CYC    = 2,
  parameter int T_EXEC_CYC = 2000,
  parameter int T_CLR_CYC  = 82000,
  parameter int CNT_W      = 17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lcd_word,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_lcd_busy,
  output logic        o_lcd_done,
  output logic        o_lcd_drop
);

  localparam logic [CNT_W-1:0] LD_AS   = CNT_W'(T_AS_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PW   = CNT_W'(T_PW_CYC - 1);
  localparam logic [CNT_W-1:0] LD_H    = CNT_W'(T_H_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC = CNT_W'(T_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLR  = CNT_W'(T_CLR_CYC - 1);

  lcd_state_e       state, state_nxt;
  logic             go_q;
  logic             req;
  lcd_req_t         req_in;
  logic             pend_vld;
  lcd_req_t         pend;
  lcd_req_t         cur;
  logic             wait_end, consume, direct, launch, store, drop;
  lcd_req_t         launch_req;
  logic             t_load, t_zero;
  logic [CNT_W-1:0] t_value;
  logic             unused_word_bits;

  assign unused_word_bits = ^{i_lcd_word[LCD_ON_BIT-1:LCD_GO_BIT+1],
                              i_lcd_word[LCD_RS_BIT-1:LCD_DATA_MSB+1]};

  // A request is any change of the GO bit relative to the previous cycle.
  assign req         = i_lcd_word[LCD_GO_BIT] ^ go_q;
  assign req_in.rs   = i_lcd_word[LCD_RS_BIT];
  assign req_in.data = i_lcd_word[LCD_DATA_MSB:0];

  assign wait_end = (state == WAIT) && t_zero;
  // Pending is drained either at the end of a wait or from IDLE (a request
  // stored during the final wait cycle finds the FSM already heading to IDLE).
  assign consume  = pend_vld && ((state == IDLE) || wait_end);
  assign direct   = req && (state == IDLE) && !pend_vld;
  assign launch   = direct || consume;
  assign launch_req = consume ? pend : req_in;
  // The slot freed by a consume in this cycle can accept a new request.
  assign store    = req && !direct && (!pend_vld || consume);
  assign drop     = req && !direct && pend_vld && !consume;

  always_comb begin
    state_nxt = state;
    t_load    = 1'b0;
    t_value   = '0;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = SETUP;
          t_load    = 1'b1;
          t_value   = LD_AS;
        end
      end
      SETUP: begin
        if (t_zero) begin
          state_nxt = PULSE;
          t_load    = 1'b1;
          t_value   = LD_PW;
        end
      end
      PULSE: begin
        if (t_zero) begin
          state_nxt = HOLD;
          t_load    = 1'b1;
          t_value   = LD_H;
        end
      end
      HOLD: begin
        if (t_zero) begin
          state_nxt = WAIT;
          t_load    = 1'b1;
          t_value   = is_long_cmd(cur) ? LD_CLR : LD_EXEC;
        end
      end
      WAIT: begin
        if (t_zero) begin
          if (launch) begin
            state_nxt = SETUP;
            t_load    = 1'b1;
            t_value   = LD_AS;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  lcd_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (i_clk),
    .rst_n(i_rst),
    .load (t_load),
    .value(t_value),
    .zero (t_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      go_q       <= 1'b0;
      pend_vld   <= 1'b0;
      cur        <= '0;
      o_lcd_on   <= 1'b0;
      o_lcd_done <= 1'b0;
      o_lcd_drop <= 1'b0;
    end else begin
      state      <= state_nxt;
      go_q       <= i_lcd_word[LCD_GO_BIT];
      o_lcd_on   <= i_lcd_word[LCD_ON_BIT];
      o_lcd_done <= wait_end;
      o_lcd_drop <= drop;
      if (launch) begin
        cur <= launch_req;
      end
      if (store) begin
        pend_vld <= 1'b1;
      end else if (consume) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Pending payload is only meaningful while pend_vld is set.
  always_ff @(posedge i_clk) begin
    if (store) begin
      pend <= req_in;
    end
  end

  assign o_lcd_rs   = cur.rs;
  assign o_lcd_data = cur.data;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = (state == PULSE);
  assign o_lcd_busy = (state != IDLE) || pend_vld;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: directed scenarios plus randomized GO
// traffic, each compared cycle by cycle against a transaction-level model.
module tb_lcd_ctrl;

  localparam int TAS  = 2;
  localparam int TPW  = 4;
  localparam int TH   = 2;
  localparam int TEX  = 10;
  localparam int TCL  = 50;
  localparam int MAXN = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] word = '0;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;
  logic        o_lcd_busy, o_lcd_done, o_lcd_drop;

  lcd_ctrl #(
    .T_AS_CYC  (TAS),
    .T_PW_CYC  (TPW),
    .T_H_CYC   (TH),
    .T_EXEC_CYC(TEX),
    .T_CLR_CYC (TCL),
    .CNT_W     (17)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_lcd_word(word),
    .o_lcd_data(o_lcd_data),
    .o_lcd_rs  (o_lcd_rs),
    .o_lcd_rw  (o_lcd_rw),
    .o_lcd_en  (o_lcd_en),
    .o_lcd_on  (o_lcd_on),
    .o_lcd_busy(o_lcd_busy),
    .o_lcd_done(o_lcd_done),
    .o_lcd_drop(o_lcd_drop)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] w      [MAXN];
  logic        e_en   [MAXN];
  logic        e_busy [MAXN];
  logic        e_done [MAXN];
  logic        e_drop [MAXN];
  logic        e_on   [MAXN];
  logic        e_rs   [MAXN];
  logic [7:0]  e_data [MAXN];

  int n_busy, n_done, n_drop, n_en, n_en_cyc;

  task automatic check(input string tag, input int t, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d got=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic set_w(input int from, input int to, input logic [31:0] v);
    for (int i = from; i <= to && i < MAXN; i++) w[i] = v;
  endtask

  // Transaction-level model: find GO changes, schedule each accepted write
  // after the previous one (one waiting slot), then paint expected outputs.
  task automatic build_model(input int n);
    int last_req, last_start, last_end, s, len;
    logic prev_go, long_w, rs;
    logic [7:0] data;
    for (int t = 0; t < MAXN; t++) begin
      e_en[t] = 0; e_busy[t] = 0; e_done[t] = 0; e_drop[t] = 0;
      e_rs[t] = 0; e_data[t] = 8'h00;
      e_on[t] = (t == 0) ? 1'b0 : w[t-1][31];
    end
    last_req = -100; last_start = -100; last_end = 0;
    for (int d = 0; d < n; d++) begin
      prev_go = (d == 0) ? 1'b0 : w[d-1][10];
      if (w[d][10] != prev_go) begin
        if (d >= last_req + 1 && d <= last_start - 2) begin
          e_drop[d+1] = 1'b1;
        end else begin
          rs     = w[d][9];
          data   = w[d][7:0];
          long_w = (rs == 1'b0) && (data == 8'd1 || data == 8'd2 || data == 8'd3);
          len    = TAS + TPW + TH + (long_w ? TCL : TEX);
          if (d >= last_end) s = d + 1;
          else s = (last_end > d + 2) ? last_end : d + 2;
          for (int i = d + 1; i < s + len && i < MAXN; i++) e_busy[i] = 1'b1;
          for (int i = s + TAS; i < s + TAS + TPW && i < MAXN; i++) e_en[i] = 1'b1;
          if (s + len < MAXN) e_done[s+len] = 1'b1;
          for (int i = s; i < MAXN; i++) begin
            e_rs[i] = rs; e_data[i] = data;
          end
          last_req = d; last_start = s; last_end = s + len;
        end
      end
    end
  endtask

  // Reset (word held at w[0]), then cycle t: sample outputs, drive w[t].
  task automatic run(input int n);
    logic prev_en;
    build_model(n);
    word  = w[0];
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_busy = 0; n_done = 0; n_drop = 0; n_en = 0; n_en_cyc = 0;
    prev_en = 1'b0;
    for (int t = 0; t < n; t++) begin
      check("en",   t, 32'(o_lcd_en),   32'(e_en[t]));
      check("busy", t, 32'(o_lcd_busy), 32'(e_busy[t]));
      check("done", t, 32'(o_lcd_done), 32'(e_done[t]));
      check("drop", t, 32'(o_lcd_drop), 32'(e_drop[t]));
      check("on",   t, 32'(o_lcd_on),   32'(e_on[t]));
      check("rs",   t, 32'(o_lcd_rs),   32'(e_rs[t]));
      check("data", t, 32'(o_lcd_data), 32'(e_data[t]));
      check("rw",   t, 32'(o_lcd_rw),   32'd0);
      n_busy   += int'(o_lcd_busy);
      n_done   += int'(o_lcd_done);
      n_drop   += int'(o_lcd_drop);
      n_en_cyc += int'(o_lcd_en);
      if (o_lcd_en && !prev_en) n_en++;
      prev_en = o_lcd_en;
      word = w[t];
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic gen_random(input int n);
    logic [31:0] cur;
    cur = '0;
    for (int t = 0; t < n; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        cur[10]   = ~cur[10];
        cur[9]    = 1'($urandom_range(0, 1));
        cur[7:0]  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        cur[8]    = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 5) == 0) cur[30:11] = 20'($urandom);
      if ($urandom_range(0, 49) == 0) cur[31] = ~cur[31];
      w[t] = cur;
    end
  endtask

  initial begin
    // 1: single data write from reset
    set_w(0, MAXN-1, 32'h0000_0441);
    run(30);
    check("s1_busy_len", 0, n_busy, TAS + TPW + TH + TEX);
    check("s1_done_cnt", 0, n_done, 1);
    check("s1_en_width", 0, n_en_cyc, TPW);
    check("s1_data",     0, {23'd0, o_lcd_rs, o_lcd_data}, 32'h041);

    // 2: RS=1 data 0x01 uses short wait; RS=0 0x01 (clear) uses long wait
    set_w(0, 1, 32'h0000_0201);
    set_w(2, 29, 32'h0000_0601);
    set_w(30, MAXN-1, 32'h0000_0001);
    run(100);
    check("s2_busy_len", 0, n_busy, 2 * (TAS + TPW + TH) + TEX + TCL);
    check("s2_done_cnt", 0, n_done, 2);

    // 3: second request during WAIT goes through pending, no idle gap
    set_w(0, 11, 32'h0000_0441);
    set_w(12, MAXN-1, 32'h0000_0042);
    run(45);
    check("s3_busy_len", 0, n_busy, 2 * (TAS + TPW + TH + TEX));
    check("s3_done_cnt", 0, n_done, 2);

    // 4: third request while pending is full is dropped
    set_w(0, 2, 32'h0000_0441);
    set_w(3, 4, 32'h0000_0042);
    set_w(5, MAXN-1, 32'h0000_0443);
    run(45);
    check("s4_drop_cnt", 0, n_drop, 1);
    check("s4_en_pulses", 0, n_en, 2);

    // 5: request in the exact cycle pending is consumed is kept
    set_w(0, 2, 32'h0000_0441);
    set_w(3, 17, 32'h0000_0042);
    set_w(18, MAXN-1, 32'h0000_0443);
    run(65);
    check("s5_drop_cnt", 0, n_drop, 0);
    check("s5_en_pulses", 0, n_en, 3);

    // randomized GO traffic
    for (int r = 0; r < 3; r++) begin
      gen_random(400);
      run(400);
    end

    // 6: asynchronous reset during PULSE of a GO=0 request
    set_w(0, 24, 32'h8000_0441);
    set_w(25, MAXN-1, 32'h8000_0042);
    run(29);
    check("s6_in_pulse", 29, 32'(o_lcd_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_en",   29, 32'(o_lcd_en),   32'd0);
    check("s6_rst_busy", 29, 32'(o_lcd_busy), 32'd0);
    check("s6_rst_done", 29, 32'(o_lcd_done), 32'd0);
    check("s6_rst_data", 29, {23'd0, o_lcd_rs, o_lcd_data}, 32'd0);
    set_w(0, MAXN-1, 32'h8000_0042);
    run(20);
    check("s6_no_busy", 0, n_busy, 0);
    check("s6_no_en",   0, n_en, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
